// File: rtl/cpu_common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_common (package)
// Description : Shared types and constants for the CPU register file slice:
//               the clear-sequencer state enum, default register file
//               geometry and the architectural word/register-address aliases.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_common;

    // Default register file geometry (32 registers of 32 bits).
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // Architectural aliases; these stay fixed at the 32x32 geometry even when
    // a register file instance is parameterised differently.
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regaddr_t;

    // Clear sequencer states.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_e;

endpackage : cpu_common
`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clear_seq
// Description : Post-reset clear sequencer for the register file. While in
//               CLEAR it walks a pointer from 0 to DEPTH-1, one entry per
//               cycle, requesting a zero write at each entry, then enters
//               READY. Any reset restarts the walk from entry 0.
// Ports       : clk_i      - clock, rising edge
//               rst_i      - synchronous active-high reset
//               busy       - high while clearing or while rst_i is high
//               clear_we   - zero-write request for the entry at clear_addr
//               clear_addr - entry currently being cleared
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_clear_seq
    import cpu_common::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          busy,
    output logic          clear_we,
    output logic [AW-1:0] clear_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clear_state_e  state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clear_we   = 1'b0;
        clear_addr = ptr_q;
        // rst_i is folded in so the outside world sees busy in the very cycle
        // reset is first asserted, before the state register has reacted.
        busy       = rst_i || (state_q == CLEAR);

        if (state_q == CLEAR && !rst_i) begin
            clear_we = 1'b1;
            if (ptr_q == LAST_ADDR) begin
                // Last entry is written on the same edge that leaves CLEAR.
                state_d = READY;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

endmodule : regfile_clear_seq
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-ported register file with READ_PORTS asynchronous read
//               ports and two synchronous write ports (port 1 wins on an
//               address collision). After reset every entry is zeroed by a
//               DEPTH-cycle clear sequence during which writes are ignored
//               and reads return zero. Optional hardwired-zero entry 0.
// Macro       : REGFILE_BYPASS_EN - when defined, a same-cycle write is
//               forwarded combinationally to reads of the same address.
// Ports       : clk_i           - clock, rising edge
//               rst_i           - synchronous active-high reset
//               rd_addr_i       - READ_PORTS x AW read addresses (port r at
//                                 bits [r*AW +: AW])
//               rd_data_async_o - READ_PORTS x WIDTH combinational read data
//               wr_enable_i     - per-write-port enables
//               wr_addr_i       - 2 x AW write addresses
//               wr_data_i       - 2 x WIDTH write data
//               busy_o          - high while the clear sequence runs
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import cpu_common::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [READ_PORTS*AW-1:0]    rd_addr_i,
    output logic [READ_PORTS*WIDTH-1:0] rd_data_async_o,
    input  logic [1:0]                  wr_enable_i,
    input  logic [2*AW-1:0]             wr_addr_i,
    input  logic [2*WIDTH-1:0]          wr_data_i,
    output logic                        busy_o
);

    localparam bit HAS_ZERO_REG = (ZERO_REG != 0);

    logic          busy;
    logic          clear_we;
    logic [AW-1:0] clear_addr;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign busy_o = busy;

    // Write-port qualification: a port only writes in READY, and never to
    // entry 0 when that entry is hardwired.
    logic [1:0]       wr_ok;
    logic [AW-1:0]    wr_addr0, wr_addr1;
    logic [WIDTH-1:0] wr_data0, wr_data1;

    assign wr_addr0 = wr_addr_i[0 +: AW];
    assign wr_addr1 = wr_addr_i[AW +: AW];
    assign wr_data0 = wr_data_i[0 +: WIDTH];
    assign wr_data1 = wr_data_i[WIDTH +: WIDTH];

    always_comb begin
        wr_ok    = 2'b00;
        wr_ok[0] = wr_enable_i[0] && !busy && !(HAS_ZERO_REG && wr_addr0 == '0);
        wr_ok[1] = wr_enable_i[1] && !busy && !(HAS_ZERO_REG && wr_addr1 == '0);
    end

    // Storage.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (clear_we) begin
            mem_d[clear_addr] = '0;
        end else begin
            // Port 1 is applied last so it overrides port 0 on a collision.
            if (wr_ok[0]) mem_d[wr_addr0] = wr_data0;
            if (wr_ok[1]) mem_d[wr_addr1] = wr_data1;
        end
    end

    // Contents are deliberately not reset: the clear sequence zeroes them.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Read ports.
    for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
        logic [AW-1:0]    rd_addr;
        logic [WIDTH-1:0] rd_val;

        assign rd_addr = rd_addr_i[r*AW +: AW];

        always_comb begin
            rd_val = mem_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok[1] && wr_addr1 == rd_addr) begin
                rd_val = wr_data1;
            end else if (wr_ok[0] && wr_addr0 == rd_addr) begin
                rd_val = wr_data0;
            end
`endif
            if (busy || (HAS_ZERO_REG && rd_addr == '0)) begin
                rd_val = '0;
            end
        end

        assign rd_data_async_o[r*WIDTH +: WIDTH] = rd_val;
    end : g_rd

endmodule : regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, meaning register count; power of two, at least 4; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter READ_PORTS, default 2, meaning number of async read ports; range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit, reset; synchronous and active-high.
REQ-007 SHALL have port rd_addr_i, input, READ_PORTS x AW, read addresses.
REQ-008 SHALL have port rd_data_async_o, output, READ_PORTS x WIDTH, combinational read data.
REQ-009 SHALL have port wr_enable_i, input, 2 bits, per-write-port enables; port 0 and port 1.
REQ-010 SHALL have port wr_addr_i, input, 2 x AW, write addresses.
REQ-011 SHALL have port wr_data_i, input, 2 x WIDTH, write data.
REQ-012 SHALL have port busy_o, output, 1 bit, high while the clear sequence runs.

Function
REQ-013 SHALL implement the states CLEAR and READY; rst_i high SHALL force the state to CLEAR with clear pointer 0.
REQ-014 In CLEAR, SHALL write zero to the entry at the clear pointer and increment the pointer every cycle rst_i is low; at pointer DEPTH-1, SHALL write that entry and move to READY on the same edge.
REQ-015 Clear latency SHALL be exactly DEPTH cycles after rst_i falls, and busy_o SHALL equal (state == CLEAR).
REQ-016 In CLEAR, SHALL ignore wr_enable_i, and rd_data_async_o SHALL read as all zeros.
REQ-017 In READY, an enabled write port SHALL store wr_data_i at wr_addr_i on the clock edge.
REQ-018 When both write ports target the same address in the same cycle, SHALL store port 1's data (port 1 priority).
REQ-019 When ZERO_REG=1, SHALL discard writes to address 0, and every read of address 0 SHALL return zero.
REQ-020 Read ports SHALL be fully independent; any number of ports MAY read the same address.
REQ-021 Assertion of rst_i mid-clear SHALL restart the clear pointer at 0, with no partial-completion shortcut.

Reset
REQ-022 While rst_i is high, busy_o SHALL be 1 and rd_data_async_o SHALL be 0 on all ports.
REQ-023 After the clear sequence completes, every entry SHALL read 0 and busy_o SHALL be 0.

Configuration
REQ-024 With REGFILE_BYPASS_EN defined, SHALL forward a READY-state enabled write to any same-cycle read of that address combinationally, with port 1 priority and the ZERO_REG rule still applied.
REQ-025 Without REGFILE_BYPASS_EN, a read SHALL return the stored value, and a write SHALL become visible the cycle after its edge.

Structure
REQ-026 The clear state enum and the default WIDTH/DEPTH constants SHALL live in cpu_common; word_t and regaddr_t SHALL remain the 32x32 aliases.
REQ-027 The clear FSM and pointer SHALL be a sub-module, regfile_clear_seq, with outputs busy, clear_we and clear_addr.

Verification
REQ-028 Reset test: pulse rst_i for 1 cycle with DEPTH=32 -> busy_o is high for exactly 32 cycles, then all 32 entries read 0.
REQ-029 Write-port collision test: in the same cycle, port 0 writes 5 <- 0xAAAA0000 and port 1 writes 5 <- 0x5555FFFF -> the next cycle, address 5 reads 0x5555FFFF on every read port.
REQ-030 Zero-register test: write 0 <- 0xDEADBEEF with ZERO_REG=1 -> address 0 reads 0; with ZERO_REG=0 -> the next cycle it reads 0xDEADBEEF.
REQ-031 Bypass test: write 7 <- 0x12345678 while reading 7 in the same cycle -> with REGFILE_BYPASS_EN the read gives 0x12345678 immediately; without it the read gives the old value that cycle and 0x12345678 the next.
REQ-032 Mid-clear reset test: assert rst_i at clear pointer 10, then release -> busy_o is high for 32 further cycles, and a write attempted during clear (3 <- 0x1) leaves entry 3 at 0.
